// File: rtl/pio_stream_bridge.sv
// Bridges a NIOS PIO word/toggle write port onto a first-word-fall-through
// valid/ready stream, with CPU-visible status (ack, overflow, level, frames).
module pio_stream_bridge #(
  parameter int DEPTH = 16
) (
  input  logic        clk_in_clk,
  input  logic        reset_reset,
  input  logic [31:0] po_export,
  input  logic [31:0] po2_export,
  output logic [31:0] pi_export,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        m_valid,
  input  logic        m_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Stream handshake: a word transfers at the rising edge where m_valid and
  // m_ready are both high; m_valid/m_data/m_last hold until that edge.
  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          tog_q, ack, overflow;
  logic [7:0]    frames;

  logic write_ev, clear, full, empty, push, drop, pop;
  logic [32:0] head;
  logic unused_po2;

  assign unused_po2 = ^po2_export[30:2];

  assign write_ev = po2_export[0] != tog_q;
  assign clear    = po2_export[31];
  assign full     = level == LW'(DEPTH);
  assign empty    = level == '0;
  // Full is taken from the registered level, so a same-cycle pop never frees room.
  assign push     = write_ev && !clear && !full;
  assign drop     = write_ev && !clear && full;
  assign pop      = m_valid && m_ready && !clear;
  assign head     = mem[rptr];

  assign m_valid = !empty;
  assign m_data  = m_valid ? head[31:0] : 32'h0;
  assign m_last  = m_valid ? head[32] : 1'b0;

  always_ff @(posedge clk_in_clk) begin
    if (push) mem[wptr] <= {po2_export[1], po_export};
  end

  always_ff @(posedge clk_in_clk or posedge reset_reset) begin
    if (reset_reset) begin
      tog_q     <= 1'b0;
      ack       <= 1'b0;
      overflow  <= 1'b0;
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      frames    <= 8'h0;
      pi_export <= 32'h0000_0008;
    end else begin
      // Status is sampled from the current registered state.
      pi_export <= {8'h0, frames, 8'(level), 4'h0, empty, full, overflow, ack};
      if (write_ev) begin
        tog_q <= po2_export[0];
        ack   <= !ack;
      end
      if (clear) begin
        wptr     <= '0;
        rptr     <= '0;
        level    <= '0;
        overflow <= 1'b0;
        frames   <= 8'h0;
      end else begin
        if (drop) overflow <= 1'b1;
        if (push) wptr <= wptr + 1'b1;
        if (pop) begin
          rptr <= rptr + 1'b1;
          if (head[32]) frames <= frames + 8'd1;
        end
        if (push && !pop)      level <= level + 1'b1;
        else if (pop && !push) level <= level - 1'b1;
      end
    end
  end

endmodule

// File: doc/pio_stream_bridge.md
PIO_STREAM_BRIDGE -- requirements
Module: pio_stream_bridge

Interface
REQ-001 Parameter: DEPTH, default 16, FIFO depth in 32-bit words; power of two, 2..128.
REQ-002 clk_in_clk  in  1  system clock, same domain as the NIOS PIO ports.
REQ-003 reset_reset  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 po_export  in  32  data word driven by the CPU PIO.
REQ-005 po2_export  in  32  control from CPU PIO: bit0 write toggle, bit1 last flag, bit31 soft clear (level); other bits ignored.
REQ-006 pi_export  out  32  status to CPU PIO input.
REQ-007 m_data  out  32  stream data to the accelerator.
REQ-008 m_last  out  1  stream end-of-frame flag.
REQ-009 m_valid  out  1  stream word valid.
REQ-010 m_ready  in  1  downstream accepts the word.

Function
REQ-011 Write event SHALL be the cycle where po2_export[0] != tog_q; at that clock edge tog_q takes po2_export[0].
REQ-012 On a write event with FIFO not full and clear low, {po2_export[1], po_export} SHALL be pushed at the same edge.
REQ-013 On a write event with FIFO full, the word SHALL be dropped and the overflow sticky bit set; full is evaluated before any same-cycle pop.
REQ-014 Every write event, accepted, dropped or cleared, SHALL invert ack at the same edge.
REQ-015 FIFO SHALL be first-word-fall-through: m_valid = not empty; m_data/m_last show the head entry.
REQ-016 Push into an empty FIFO SHALL raise m_valid one cycle after the write-event cycle.
REQ-017 Pop SHALL occur at the edge where m_valid and m_ready are both high; a simultaneous push and pop leaves the level unchanged.
REQ-018 m_data and m_last SHALL be 0 while m_valid is low.
REQ-019 m_valid SHALL hold with m_data/m_last stable until m_ready is high.
REQ-020 Read and write pointers SHALL wrap modulo DEPTH; the level counter spans 0..DEPTH inclusive.
REQ-021 The frame counter (8 bit) SHALL increment on each pop with m_last=1 and wrap 255->0.
REQ-022 While po2_export[31]=1, at each edge: pointers, level and overflow are cleared, no push occurs, and the frame counter is cleared.
REQ-023 During clear, write events SHALL still update tog_q and invert ack.
REQ-024 A pop handshake coinciding with clear SHALL be discarded; the frame counter is not incremented.
REQ-025 pi_export layout: [0] ack, [1] overflow, [2] full, [3] empty, [7:4] 0, [15:8] level, [23:16] frame count, [31:24] 0.
REQ-026 pi_export SHALL be registered and reflect state one cycle after the causing edge.

Reset
REQ-027 While reset_reset=1: tog_q=0, ack=0, overflow=0, pointers/level/frame count=0.
REQ-028 Reset outputs: pi_export=0x00000008, m_valid=0, m_data=0, m_last=0.
REQ-029 Reset SHALL abort any pending transfer and discard FIFO contents; the CPU driver restores po2_export[0]=0 after reset.

Verification
REQ-030 Single write: po_export=0xCAFE0001, toggle bit0 0->1, m_ready=1 -> m_valid is high for exactly one cycle with 0xCAFE0001 and m_last=0; ack=1; level returns to 0.
REQ-031 Fill with m_ready=0, DEPTH=16: 17 toggles -> 16 words stored; pi_export[2]=1; [15:8]=16; [1]=1; the 17th word does not appear on drain.
REQ-032 Backpressure: 3 words A,B,C; m_ready pattern 0,1,0,0,1,1 -> output order A,B,C; data stable while stalled.
REQ-033 Frames: 4 words, the 2nd and 4th with bit1=1, then drain -> frame count=2 and m_last high on exactly those words.
REQ-034 Clear: 5 words queued plus overflow set, pulse bit31 for 1 cycle with a write toggle in the same cycle -> pi_export=0x00000009 (ack inverted, empty=1).
REQ-035 Async reset asserted mid-drain, between clock edges -> m_valid low and pi_export=0x00000008 immediately, before the next edge.
